// File: rtl/irq_pkg.sv
// Shared types and sizes for the interrupt latch/arbiter.
// Optional drop counter is enabled by defining IRQ_DROP_CNT_EN.
package irq_pkg;

    localparam int NUM_REQ = 4;
    localparam int CODE_W  = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } irq_state_e;

endpackage

// File: rtl/irq_prio_sel.sv
// Highest-index-wins selector over the masked pending vector.
// Purely combinational; bit 3 has top priority.
module irq_prio_sel
    import irq_pkg::*;
(
    input  logic [NUM_REQ-1:0] in,
    output logic [CODE_W-1:0]  code,
    output logic               any
);

    // Several bits may be set at once, so this is a priority chain.
    always_comb begin
        code = '0;
        any  = 1'b1;
        priority case (1'b1)
            in[3]:   code = 2'd3;
            in[2]:   code = 2'd2;
            in[1]:   code = 2'd1;
            in[0]:   code = 2'd0;
            default: any  = 1'b0;
        endcase
    end

endmodule

// File: rtl/irq_latch_arb.sv
// Latches request events and presents them one at a time, by priority.
// Define IRQ_DROP_CNT_EN to add the saturating drop_cnt output.
module irq_latch_arb
    import irq_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_valid,
    input  logic               out_ack,
    output logic [NUM_REQ-1:0] pending
`ifdef IRQ_DROP_CNT_EN
    ,
    output logic [7:0]         drop_cnt
`endif
);

    irq_state_e         state;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] evt;
    logic [NUM_REQ-1:0] clr;
    logic [NUM_REQ-1:0] pending_d;
    logic [NUM_REQ-1:0] masked;
    logic [CODE_W-1:0]  sel_code;
    logic               sel_any;

    assign evt = (EDGE_MODE != 0) ? (req & ~req_q) : req;

    // Only an ack against a live presentation clears anything.
    assign clr = (state == PRESENT && out_ack)
               ? (NUM_REQ'(1) << out_code) : '0;

    // A new event beats the clear of the same bit.
    assign pending_d = (pending & ~clr) | evt;
    assign masked    = pending & mask;

    irq_prio_sel u_sel (
        .in   (masked),
        .code (sel_code),
        .any  (sel_any)
    );

    // Request history and latched pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            pending <= pending_d;
        end
    end

    // Presentation FSM; code/valid frozen until acked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_code  <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sel_any) begin
                        out_code  <= sel_code;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IRQ_DROP_CNT_EN
    logic drop_any;

    // An event on a bit that stays pending is lost.
    assign drop_any = |(evt & pending & ~clr);

    // Saturating count of cycles that lost at least one event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_any && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_irq_latch_arb.sv
// Self-checking bench for irq_latch_arb: directed table,
// hand-written corner sequences and a randomized model comparison.
module tb_irq_latch_arb;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] mask = '0;
    logic       out_ack = 1'b0;
    logic [1:0] out_code;
    logic       out_valid;
    logic [3:0] pending;
`ifdef IRQ_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_latch_arb #(.EDGE_MODE(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .pending   (pending)
`ifdef IRQ_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] m,
                         input logic a);
        req = r;
        mask = m;
        out_ack = a;
    endtask

    // Reference model: per-bit flags, one presentation slot.
    bit m_pend[4];
    bit m_prev[4];
    bit m_busy;
    int m_code;
    int m_drops;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_prev[i] = 0;
        end
        m_busy = 0;
        m_code = 0;
        m_drops = 0;
    endfunction

    function automatic void model_edge(input logic [3:0] r,
                                       input logic [3:0] m,
                                       input logic a);
        bit ev[4];
        bit np[4];
        int cleared;
        bit lost;
        cleared = (m_busy && a) ? m_code : -1;
        lost = 0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = r[i] && !m_prev[i];
            if (ev[i] && m_pend[i] && i != cleared) lost = 1;
            np[i] = ev[i] || (m_pend[i] && i != cleared);
        end
        if (lost && m_drops < 255) m_drops++;
        if (m_busy) begin
            if (a) m_busy = 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && m[i]) begin
                    m_busy = 1;
                    m_code = i;
                end
        end
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = r[i];
        end
    endfunction

    function automatic int model_pending();
        int v = 0;
        for (int i = 0; i < 4; i++)
            if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic       ack;
        logic       ev;
        logic [1:0] ec;
        logic [3:0] ep;
    } vec_t;

    vec_t tbl[16];

    task automatic do_reset();
        drive(4'h0, 4'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        tbl[0]  = '{4'b0001, 4'hF, 1'b0, 1'b0, 2'd0, 4'b0001};
        tbl[1]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd0, 4'b0001};
        tbl[2]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[3]  = '{4'b0000, 4'hF, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[4]  = '{4'b1010, 4'hF, 1'b0, 1'b0, 2'd0, 4'b1010};
        tbl[5]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd3, 4'b1010};
        tbl[6]  = '{4'b0000, 4'h0, 1'b0, 1'b1, 2'd3, 4'b1010};
        tbl[7]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0010};
        tbl[8]  = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd1, 4'b0010};
        tbl[9]  = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b1000, 4'h7, 1'b0, 1'b0, 2'd0, 4'b1000};
        tbl[11] = '{4'b0000, 4'h7, 1'b0, 1'b0, 2'd0, 4'b1000};
        tbl[12] = '{4'b0000, 4'h7, 1'b0, 1'b0, 2'd0, 4'b1000};
        tbl[13] = '{4'b0000, 4'hF, 1'b0, 1'b1, 2'd3, 4'b1000};
        tbl[14] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[15] = '{4'b0000, 4'hF, 1'b1, 1'b0, 2'd0, 4'b0000};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_code", int'(out_code), 0);
        chk("rst_pending", int'(pending), 0);
`ifdef IRQ_DROP_CNT_EN
        chk("rst_drop", int'(drop_cnt), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].req, tbl[i].mask, tbl[i].ack);
            step();
            chk($sformatf("tbl%0d_valid", i), int'(out_valid),
                int'(tbl[i].ev));
            chk($sformatf("tbl%0d_pending", i), int'(pending),
                int'(tbl[i].ep));
            if (tbl[i].ev)
                chk($sformatf("tbl%0d_code", i), int'(out_code),
                    int'(tbl[i].ec));
        end

        // Event on bit 2 lands in the same cycle as its ack.
        drive(4'b0100, 4'hF, 1'b0); step();
        drive(4'b0000, 4'hF, 1'b0); step();
        chk("race_code", int'(out_code), 2);
        chk("race_valid", int'(out_valid), 1);
        drive(4'b0100, 4'hF, 1'b1); step();
        chk("race_pend", int'(pending), 4'b0100);
        chk("race_gap", int'(out_valid), 0);
        drive(4'b0000, 4'hF, 1'b0); step();
        chk("race_re_valid", int'(out_valid), 1);
        chk("race_re_code", int'(out_code), 2);
        drive(4'b0000, 4'hF, 1'b1); step();
        chk("race_done", int'(pending), 0);
        drive(4'b0000, 4'hF, 1'b0); step();

`ifdef IRQ_DROP_CNT_EN
        // Repeated pulses on a masked, already pending bit.
        for (int k = 0; k < 301; k++) begin
            drive(4'b0001, 4'h0, 1'b0); step();
            drive(4'b0000, 4'h0, 1'b0); step();
        end
        chk("drop_sat", int'(drop_cnt), 8'hFF);
        chk("drop_pend", int'(pending), 4'b0001);
        do_reset();
`endif

        // Reset in the middle of a presentation, req held high.
        drive(4'b0001, 4'hF, 1'b0); step();
        drive(4'b0001, 4'hF, 1'b0); step();
        chk("mid_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_pend", int'(pending), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("recap_pend", int'(pending), 4'b0001);
        step();
        chk("recap_valid", int'(out_valid), 1);
        chk("recap_code", int'(out_code), 0);

        // Randomized comparison against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] r;
            logic [3:0] m;
            logic a;
            r = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            m = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            a = ($urandom_range(0, 2) == 0);
            drive(r, m, a);
            model_edge(r, m, a);
            step();
            chk("rnd_valid", int'(out_valid), int'(m_busy));
            chk("rnd_pending", int'(pending), model_pending());
            if (m_busy) chk("rnd_code", int'(out_code), m_code);
`ifdef IRQ_DROP_CNT_EN
            chk("rnd_drop", int'(drop_cnt), m_drops);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
